multiply_divide_unit: RTL and testbench
=======================================

// Module: multiply_divide_unit
// PURPOSE
//  Multi-cycle MIPS multiply/divide unit owning the HI/LO register pair.
//  The execute stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO with one-cycle start.
//  The unit asserts busy while iterating; the pipeline stalls MFHI/MFLO and any
//  new mul/div op until busy drops. Sits beside the ALU, on the same A/B operand buses.
// PARAMETERS
//  MUL_CYCLES  4   cycles from start to result for MULT/MULTU (range 1..8)
//  DIV_CYCLES  32  cycles from start to result for DIV/DIVU (fixed radix-2, one quotient bit/cycle)
// PORTS
//  clk       in   1   rising-edge clock
//  reset     in   1   synchronous, active-high reset
//  start     in   1   issue strobe; op/A/B are sampled on this cycle
//  op        in   4   mduMult=0, mduMultu=1, mduDiv=2, mduDivu=3, mduMthi=4, mduMtlo=5,
//                     mduMadd=6, mduMaddu=7, mduMsub=8, mduMsubu=9; others are no-ops
//  A         in   32  rs operand (dividend / multiplicand / MTHI-MTLO source)
//  B         in   32  rt operand (divisor / multiplier)
//  cancel    in   1   exception flush: abort the in-flight op, HI/LO unchanged
//  busy      out  1   high while a mul/div op is in flight
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  - reset: busy=0, hi=0, lo=0, counter=0, FSM=IDLE. Reset wins over start and cancel.
//  - FSM states: IDLE, MUL, DIV.
//    * IDLE + start + mul op -> MUL, counter = MUL_CYCLES-1.
//    * IDLE + start + div op -> DIV, counter = DIV_CYCLES-1.
//    * MUL/DIV: counter decrements each cycle.
//      At counter==0, hi/lo are written on that edge, then -> IDLE.
//  - busy is registered: high from the cycle after start until the cycle after
//    hi/lo update. Result is visible on hi/lo exactly N cycles after the start edge
//    (N = MUL_CYCLES or DIV_CYCLES), the same cycle busy falls.
//  - start while busy: ignored entirely (op, A, B dropped; no state change).
//  - MTHI/MTLO in IDLE: hi<=A or lo<=A on the start edge; busy never asserts.
//  - cancel while busy: -> IDLE next edge, busy=0, hi/lo keep pre-op values.
//    cancel together with start in IDLE: start is dropped.
//  - MULT: {hi,lo} = signed(A)*signed(B), 64-bit two's complement.
//    MULTU: {hi,lo} = unsigned product. No overflow is flagged.
//  - DIVU: lo=A/B, hi=A%B. DIV: quotient truncates toward zero, remainder takes the
//    sign of the dividend. Operands are captured at start; A/B may change afterwards.
//  - Divide by zero (both forms): lo=32'hFFFF_FFFF, hi=A, full DIV_CYCLES latency.
//  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
//  - Ops 6..9 without MDU_MADD_EN, and ops 10..15: treated as no-op (no busy, no write).
// CONFIGURATION
//  MDU_MADD_EN defined: ops 6..9 enabled, with MUL_CYCLES latency.
//    * MADD/MADDU:  {hi,lo} += product (signed/unsigned).
//    * MSUB/MSUBU:  {hi,lo} -= product.
//    * 64-bit wrap-around; the HI/LO value used is the one at start.
//  MDU_MADD_EN undefined: no accumulator adder is built; ops 6..9 are no-ops.
// TESTING
//  1. reset high 2 cycles -> hi=0, lo=0, busy=0; start with reset=1 -> no effect.
//  2. MULT A=-3 (FFFF_FFFD), B=7 -> after MUL_CYCLES: hi=FFFF_FFFF, lo=FFFF_FFEB, busy falls.
//  3. DIVU A=100, B=7 -> busy 32 cycles, lo=14, hi=2.
//     DIV A=-7, B=2 -> lo=FFFF_FFFD, hi=FFFF_FFFF.
//  4. DIV A=5, B=0 -> lo=FFFF_FFFF, hi=5.
//     DIV A=8000_0000, B=FFFF_FFFF -> lo=8000_0000, hi=0.
//  5. DIVU in flight, second start MULT at cycle 5, cancel at cycle 10 -> MULT ignored,
//     busy=0 at cycle 11, hi/lo unchanged. MTHI A=1234 then -> hi=1234 next cycle.
//  6. MDU_MADD_EN: hi=0, lo=FFFF_FFFF, MADDU A=1, B=1 -> hi=1, lo=0.
//     Without the macro: same stimulus -> no busy, hi/lo unchanged.

Source files
------------

// File: rtl/multiply_divide_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO (radix-2 restoring divider).
// Optional MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulation into HI/LO.
module multiply_divide_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [4:0]  cnt_r, cnt_s;
  logic [3:0]  op_r, op_s;
  logic [31:0] a_r, a_s;      // multiplicand, or dividend/quotient shift register
  logic [31:0] b_r, b_s;      // multiplier, or divisor magnitude
  logic [31:0] rem_r, rem_s;
  logic        neg_q_r, neg_q_s;
  logic        neg_r_r, neg_r_s;
  logic        busy_r, busy_s;
  logic [31:0] hi_r, hi_s;
  logic [31:0] lo_r, lo_s;

  logic [63:0] ma_s, mb_s, prod_s, mul_res_s;
  logic [63:0] div_nxt_s;
  logic        sa_s, sb_s;

  function automatic logic is_mul_op(input logic [3:0] o);
    case (o)
      OP_MULT, OP_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input logic [3:0] o);
    case (o)
      OP_MULT, OP_DIV: return 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // One restoring step: returns {remainder, quotient-shift}. Remainder stays below divisor.
  function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                           input logic [31:0] dsr);
    logic [32:0] sh;
    logic [32:0] diff;
    sh   = {rem, quo[31]};
    diff = sh - {1'b0, dsr};
    if (!diff[32]) begin
      return {diff[31:0], quo[30:0], 1'b1};
    end else begin
      return {sh[31:0], quo[30:0], 1'b0};
    end
  endfunction

  // Datapath: low 64 bits of the extended product are correct for both signednesses.
  always_comb begin
    ma_s      = {{32{a_r[31] & is_signed_op(op_r)}}, a_r};
    mb_s      = {{32{b_r[31] & is_signed_op(op_r)}}, b_r};
    prod_s    = ma_s * mb_s;
    div_nxt_s = div_step(rem_r, a_r, b_r);
`ifdef MDU_MADD_EN
    case (op_r)
      OP_MADD, OP_MADDU: mul_res_s = {hi_r, lo_r} + prod_s;
      OP_MSUB, OP_MSUBU: mul_res_s = {hi_r, lo_r} - prod_s;
      default:           mul_res_s = prod_s;
    endcase
`else
    mul_res_s = prod_s;
`endif
  end

  // Next-state and next-register logic for the IDLE/MUL/DIV sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    op_s    = op_r;
    a_s     = a_r;
    b_s     = b_r;
    rem_s   = rem_r;
    neg_q_s = neg_q_r;
    neg_r_s = neg_r_r;
    busy_s  = busy_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    sa_s    = A[31] & is_signed_op(op);
    sb_s    = B[31] & is_signed_op(op);
    case (state_r)
      IDLE: begin
        if (start && !cancel) begin
          if (is_mul_op(op)) begin
            state_s = MUL;
            cnt_s   = 5'(MUL_CYCLES - 1);
            op_s    = op;
            a_s     = A;
            b_s     = B;
            busy_s  = 1'b1;
          end else if ((op == OP_DIV) || (op == OP_DIVU)) begin
            // A zero divisor keeps the raw dividend so the restoring loop yields hi=A, lo=all ones.
            state_s = DIV;
            cnt_s   = 5'(DIV_CYCLES - 1);
            op_s    = op;
            a_s     = (sa_s && (B != 32'd0)) ? (32'd0 - A) : A;
            b_s     = sb_s ? (32'd0 - B) : B;
            rem_s   = 32'd0;
            neg_q_s = (sa_s ^ sb_s) && (B != 32'd0);
            neg_r_s = sa_s && (B != 32'd0);
            busy_s  = 1'b1;
          end else if (op == OP_MTHI) begin
            hi_s = A;
          end else if (op == OP_MTLO) begin
            lo_s = A;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        if (cancel) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else if (cnt_r == 5'd0) begin
          hi_s    = mul_res_s[63:32];
          lo_s    = mul_res_s[31:0];
          state_s = IDLE;
          busy_s  = 1'b0;
        end else begin
          cnt_s = cnt_r - 5'd1;
        end
      end
      DIV: begin
        if (cancel) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else begin
          rem_s = div_nxt_s[63:32];
          a_s   = div_nxt_s[31:0];
          if (cnt_r == 5'd0) begin
            lo_s    = neg_q_r ? (32'd0 - div_nxt_s[31:0])  : div_nxt_s[31:0];
            hi_s    = neg_r_r ? (32'd0 - div_nxt_s[63:32]) : div_nxt_s[63:32];
            state_s = IDLE;
            busy_s  = 1'b0;
          end else begin
            cnt_s = cnt_r - 5'd1;
          end
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset takes priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
      op_r    <= 4'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      rem_r   <= 32'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      busy_r  <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      op_r    <= op_s;
      a_r     <= a_s;
      b_r     <= b_s;
      rem_r   <= rem_s;
      neg_q_r <= neg_q_s;
      neg_r_r <= neg_r_s;
      busy_r  <= busy_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Directed self-checking bench for multiply_divide_unit; honours MDU_MADD_EN when defined.
module tb_multiply_divide_unit;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks_r;
  int failures_r;

  multiply_divide_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      failures_r++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    step();
    start = 1'b0;
    A     = 32'hDEAD_BEEF;
    B     = 32'h0BAD_F00D;
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    logic [31:0] hi0;
    logic [31:0] lo0;
    hi0 = hi;
    lo0 = lo;
    issue(o, a, b);
    check({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
    for (int i = 1; i < n; i++) step();
    check({tag, "_busy_late"}, {31'd0, busy}, 32'd1);
    check({tag, "_hi_early"}, hi, hi0);
    check({tag, "_lo_early"}, lo, lo0);
    step();
    check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    logic [31:0] hi_keep;
    logic [31:0] lo_keep;
    checks_r   = 0;
    failures_r = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 4'd0;
    A      = 32'd0;
    B      = 32'd0;
    cancel = 1'b0;
    step();
    step();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    // Start and MTHI under reset must have no effect.
    start = 1'b1; op = 4'd0; A = 32'd5; B = 32'd5;
    step();
    op = 4'd4;
    step();
    start = 1'b0;
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    check("rst_start_hi", hi, 32'd0);
    reset = 1'b0;
    step();
    check("idle_busy", {31'd0, busy}, 32'd0);

    run_op("mult", 4'd0, 32'hFFFF_FFFD, 32'd7, MUL_N, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_N, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("divu", 4'd3, 32'd100, 32'd7, DIV_N, 32'd2, 32'd14);
    run_op("div_neg", 4'd2, 32'hFFFF_FFF9, 32'd2, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb", 4'd2, 32'd7, 32'hFFFF_FFFE, DIV_N, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_zero", 4'd2, 32'd5, 32'd0, DIV_N, 32'd5, 32'hFFFF_FFFF);
    run_op("divu_zero", 4'd3, 32'h8000_0001, 32'd0, DIV_N, 32'h8000_0001, 32'hFFFF_FFFF);
    run_op("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'd0, 32'h8000_0000);

    // DIVU in flight, ignored MULT at cycle 5, cancel at cycle 10.
    hi_keep = hi;
    lo_keep = lo;
    issue(4'd3, 32'd100, 32'd7);
    for (int i = 1; i < 5; i++) step();
    issue(4'd0, 32'd3, 32'd3);
    for (int i = 6; i < 10; i++) step();
    check("cancel_pre_busy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < DIV_N; i++) step();
    check("cancel_busy_stays", {31'd0, busy}, 32'd0);
    check("cancel_hi", hi, hi_keep);
    check("cancel_lo", lo, lo_keep);

    issue(4'd4, 32'd1234, 32'd0);
    check("mthi_hi", hi, 32'd1234);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_lo", lo, lo_keep);
    // Start together with cancel in IDLE is dropped.
    cancel = 1'b1;
    issue(4'd5, 32'h5555_5555, 32'd0);
    cancel = 1'b0;
    check("cancel_start_lo", lo, lo_keep);
    // Undefined op 12 is a no-op.
    issue(4'd12, 32'h1111_1111, 32'd3);
    check("noop_busy", {31'd0, busy}, 32'd0);
    check("noop_hi", hi, 32'd1234);

    issue(4'd4, 32'd0, 32'd0);
    issue(4'd5, 32'hFFFF_FFFF, 32'd0);
    check("mtlo_lo", lo, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", 4'd7, 32'd1, 32'd1, MUL_N, 32'd1, 32'd0);
    run_op("msub", 4'd8, 32'd2, 32'hFFFF_FFFF, MUL_N, 32'd1, 32'd2);
`else
    issue(4'd7, 32'd1, 32'd1);
    check("maddu_off_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < MUL_N; i++) step();
    check("maddu_off_busy2", {31'd0, busy}, 32'd0);
    check("maddu_off_hi", hi, 32'd0);
    check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
